// File: rtl/rca_wb_buffer.sv
// rca_wb_buffer: in-order result buffer between the RCA execution unit and the
// Taiga writeback stage. Results are queued as {id, rd} in a circular FIFO and
// handed to writeback over a done/ack handshake. in_ready is derived only from
// registered occupancy, so the unit never sees a combinational path from wb_ack.
// Optional feature: define RCA_WB_BYPASS_EN for a zero-latency path while empty.
module rca_wb_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ID_W  = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [ID_W-1:0]        in_id,
    input  logic [XLEN-1:0]        in_rd,
    output logic                   in_ready,
    output logic                   wb_done,
    output logic [ID_W-1:0]        wb_id,
    output logic [XLEN-1:0]        wb_rd,
    input  logic                   wb_ack,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [ID_W-1:0] r_mem_id [DEPTH];
    logic [XLEN-1:0] r_mem_rd [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [ID_W-1:0] w_head_id;
    logic [XLEN-1:0] w_head_rd;

    // Occupancy flags, head read, handshake outputs and push/pop qualification.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == Full);
        in_ready  = !w_full;
        w_head_id = r_mem_id[r_rd_ptr];
        w_head_rd = r_mem_rd[r_rd_ptr];
        // Pointer pop only ever consumes a stored entry.
        w_pop     = wb_ack && !w_empty;
`ifdef RCA_WB_BYPASS_EN
        // While empty, the incoming result is presented directly; if it is
        // acknowledged in the same cycle it never enters storage.
        wb_done   = !w_empty || in_valid;
        wb_id     = w_empty ? (in_valid ? in_id : '0) : w_head_id;
        wb_rd     = w_empty ? (in_valid ? in_rd : '0) : w_head_rd;
        w_push    = in_valid && !w_full && !(w_empty && wb_ack);
`else
        wb_done   = !w_empty;
        wb_id     = w_empty ? '0 : w_head_id;
        wb_rd     = w_empty ? '0 : w_head_rd;
        w_push    = in_valid && !w_full;
`endif
        count     = r_count;
    end

    // Result storage; contents need no reset since outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_id[r_wr_ptr] <= in_id;
            r_mem_rd[r_wr_ptr] <= in_rd;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    // Flag a result offered while full; the buffer drops it.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(in_valid && !in_ready))
                else $warning("rca_wb_buffer: result offered while full was dropped");
        end
    end

endmodule

// File: tb/tb_rca_wb_buffer.sv
// Bench for rca_wb_buffer: queue-based reference model checked every cycle on
// the falling edge, plus directed scenarios with literal expected values.
module tb_rca_wb_buffer;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned DEPTH = 4;
`ifdef RCA_WB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [ID_W-1:0]        in_id = '0;
    logic [XLEN-1:0]        in_rd = '0;
    logic                   wb_ack = 1'b0;
    logic                   in_ready;
    logic                   wb_done;
    logic [ID_W-1:0]        wb_id;
    logic [XLEN-1:0]        wb_rd;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_err = 0;

    rca_wb_buffer #(
        .XLEN (XLEN),
        .ID_W (ID_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_id   (in_id),
        .in_rd   (in_rd),
        .in_ready(in_ready),
        .wb_done (wb_done),
        .wb_id   (wb_id),
        .wb_rd   (wb_rd),
        .wb_ack  (wb_ack),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain FIFO of results in acceptance order.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] rd;
    } res_t;

    res_t            q[$];
    logic [ID_W-1:0] accepted[$];
    logic [ID_W-1:0] popped[$];
    bit              track = 1'b0;
    int              max_cnt = 0;

    // Model update: accept if not full (pre-edge occupancy), retire head on ack.
    always @(posedge clk or posedge rst) begin
        bit accept;
        bit byp_take;
        if (rst) begin
            q.delete();
        end else begin
            accept   = in_valid && (q.size() < DEPTH);
            byp_take = Bypass && (q.size() == 0) && in_valid && wb_ack;
            if (track && accept) accepted.push_back(in_id);
            if (!byp_take) begin
                if (wb_ack && q.size() > 0) void'(q.pop_front());
                if (accept) q.push_back('{id: in_id, rd: in_rd});
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic            e_done;
        logic [ID_W-1:0] e_id;
        logic [XLEN-1:0] e_rd;
        e_done = (q.size() > 0) || (Bypass && in_valid);
        if (q.size() > 0) begin
            e_id = q[0].id;
            e_rd = q[0].rd;
        end else if (e_done) begin
            e_id = in_id;
            e_rd = in_rd;
        end else begin
            e_id = '0;
            e_rd = '0;
        end
        check("model_wb_done", 64'(wb_done), 64'(e_done));
        check("model_wb_id", 64'(wb_id), 64'(e_id));
        check("model_wb_rd", 64'(wb_rd), 64'(e_rd));
        check("model_count", 64'(count), 64'(q.size()));
        check("model_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
        if (track) begin
            if (wb_ack && wb_done) popped.push_back(wb_id);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
    end

    initial begin
        // Reset then idle.
        #12 rst = 1'b0;
        #1;
        check("idle_done", 64'(wb_done), 64'd0);
        check("idle_ready", 64'(in_ready), 64'd1);
        check("idle_count", 64'(count), 64'd0);
        check("idle_id", 64'(wb_id), 64'd0);
        check("idle_rd", 64'(wb_rd), 64'd0);

        // Ack with nothing pending is ignored.
        wb_ack = 1'b1;
        step();
        step();
        check("stray_ack_count", 64'(count), 64'd0);
        check("stray_ack_done", 64'(wb_done), 64'd0);
        wb_ack = 1'b0;

        // Single result id=2, rd=0x30.
        in_valid = 1'b1;
        in_id    = 3'd2;
        in_rd    = 32'h0000_0030;
        wb_ack   = Bypass;
        #1;
`ifdef RCA_WB_BYPASS_EN
        check("single_byp_done", 64'(wb_done), 64'd1);
        check("single_byp_id", 64'(wb_id), 64'd2);
        check("single_byp_rd", 64'(wb_rd), 64'h30);
`endif
        step();
        in_valid = 1'b0;
        wb_ack   = 1'b1;
        #1;
`ifdef RCA_WB_BYPASS_EN
        check("single_byp_count", 64'(count), 64'd0);
`else
        check("single_done", 64'(wb_done), 64'd1);
        check("single_id", 64'(wb_id), 64'd2);
        check("single_rd", 64'(wb_rd), 64'h30);
        check("single_count", 64'(count), 64'd1);
`endif
        step();
        check("single_count_after", 64'(count), 64'd0);
        check("single_done_after", 64'(wb_done), 64'd0);
        wb_ack = 1'b0;

        // Fill with ids 0..3.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_id    = ID_W'(i);
            in_rd    = 32'h10 + 32'(i);
            step();
        end
        check("fill_count", 64'(count), 64'd4);
        check("fill_ready", 64'(in_ready), 64'd0);
        check("fill_head_id", 64'(wb_id), 64'd0);
        check("fill_head_rd", 64'(wb_rd), 64'h10);
        // Overflow attempt with id=4 is dropped.
        in_id = 3'd4;
        in_rd = 32'h14;
        step();
        step();
        check("overflow_count", 64'(count), 64'd4);
        check("overflow_head_id", 64'(wb_id), 64'd0);

        // Drain while full with in_valid still high: only the pop happens.
        wb_ack = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        check("drain_full_count", 64'(count), 64'd3);
        check("drain_full_ready", 64'(in_ready), 64'd1);
        for (int e = 1; e < 4; e++) begin
            check("drain_order_id", 64'(wb_id), 64'(e));
            check("drain_order_rd", 64'(wb_rd), 64'h10 + 64'(e));
            step();
        end
        check("drain_empty_done", 64'(wb_done), 64'd0);
        check("drain_empty_count", 64'(count), 64'd0);
        wb_ack = 1'b0;

        // Streaming: 20 results with continuous push and ack.
        accepted.delete();
        popped.delete();
        max_cnt = 0;
        track   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_id    = ID_W'(i % 8);
            in_rd    = 32'h100 + 32'(i);
            wb_ack   = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        track  = 1'b0;
        wb_ack = 1'b0;
        check("stream_accepted", 64'(accepted.size()), 64'd20);
        check("stream_popped", 64'(popped.size()), 64'd20);
        for (int k = 0; k < popped.size() && k < 20; k++) begin
            check("stream_order", 64'(popped[k]), 64'(k % 8));
        end
`ifdef RCA_WB_BYPASS_EN
        check("stream_max_count", 64'(max_cnt), 64'd0);
`else
        check("stream_max_count", 64'(max_cnt), 64'd1);
`endif

        // Reset mid-operation with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_id    = ID_W'(i + 1);
            in_rd    = 32'h200 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        check("pre_reset_count", 64'(count), 64'd3);
        #3 rst = 1'b1;
        #1;
        check("async_reset_done", 64'(wb_done), 64'd0);
        check("async_reset_count", 64'(count), 64'd0);
        check("async_reset_ready", 64'(in_ready), 64'd1);
        check("async_reset_id", 64'(wb_id), 64'd0);
        #2 rst = 1'b0;
        in_valid = 1'b1;
        in_id    = 3'd5;
        in_rd    = 32'h55;
        step();
        in_valid = 1'b0;
        #1;
        check("post_reset_done", 64'(wb_done), 64'd1);
        check("post_reset_id", 64'(wb_id), 64'd5);
        check("post_reset_rd", 64'(wb_rd), 64'h55);
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        check("post_reset_drained", 64'(count), 64'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
